// File: rtl/pt_axi4lite_rf_bridge.sv
// AXI4-Lite slave to register-file bridge: one transaction at a time, variable-latency
// downstream handshake with timeout, strobe pass-through, misalignment rejection, fair arbitration.
module pt_axi4lite_rf_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 16
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [ADDR_W-1:0]   i_awaddr,
   input  logic                i_awvalid,
   output logic                o_awready,
   input  logic [DATA_W-1:0]   i_wdata,
   input  logic [DATA_W/8-1:0] i_wstrb,
   input  logic                i_wvalid,
   output logic                o_wready,
   output logic [1:0]          o_bresp,
   output logic                o_bvalid,
   input  logic                i_bready,
   input  logic [ADDR_W-1:0]   i_araddr,
   input  logic                i_arvalid,
   output logic                o_arready,
   output logic [DATA_W-1:0]   o_rdata,
   output logic [1:0]          o_rresp,
   output logic                o_rvalid,
   input  logic                i_rready,
   output logic [ADDR_W-1:0]   o_rf_address,
   output logic [DATA_W-1:0]   o_rf_wr_data,
   output logic [DATA_W/8-1:0] o_rf_wr_strb,
   output logic                o_rf_write,
   output logic                o_rf_enable,
   input  logic [DATA_W-1:0]   i_rf_rd_data,
   input  logic                i_rf_ready,
   input  logic                i_rf_error
);

   localparam int STRB_W  = DATA_W / 8;
   localparam int ALIGN_W = $clog2(STRB_W);
   localparam logic [7:0] WAIT_LAST   = 8'(TIMEOUT - 1);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP_W, RESP_R} state_t;

   state_t              state_q;
   logic                last_was_write_q;
   logic                is_write_q;
   logic [7:0]          wait_q;
   logic [ADDR_W-1:0]   rf_address_q;
   logic [DATA_W-1:0]   rf_wr_data_q;
   logic [STRB_W-1:0]   rf_wr_strb_q;
   logic                rf_write_q;
   logic                rf_enable_q;
   logic                bvalid_q;
   logic [1:0]          bresp_q;
   logic                rvalid_q;
   logic [1:0]          rresp_q;
   logic [DATA_W-1:0]   rdata_q;

   logic wr_cand, rd_cand, grant_wr, grant_rd, accept_ok;
   logic aw_misaligned, ar_misaligned, timeout_hit;

   // The type not served last wins when both candidates are present.
   assign wr_cand   = i_awvalid & i_wvalid;
   assign rd_cand   = i_arvalid;
   assign grant_wr  = wr_cand & (~rd_cand | ~last_was_write_q);
   assign grant_rd  = rd_cand & ~grant_wr;
   assign accept_ok = (state_q == IDLE) & ~i_rst;

   assign o_awready = accept_ok & grant_wr;
   assign o_wready  = accept_ok & grant_wr;
   assign o_arready = accept_ok & grant_rd;

   assign aw_misaligned = (i_awaddr[ALIGN_W-1:0] != '0);
   assign ar_misaligned = (i_araddr[ALIGN_W-1:0] != '0);
   assign timeout_hit   = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q          <= IDLE;
         last_was_write_q <= 1'b0;
         is_write_q       <= 1'b0;
         wait_q           <= '0;
         rf_address_q     <= '0;
         rf_wr_data_q     <= '0;
         rf_wr_strb_q     <= '0;
         rf_write_q       <= 1'b0;
         rf_enable_q      <= 1'b0;
         bvalid_q         <= 1'b0;
         bresp_q          <= RESP_OKAY;
         rvalid_q         <= 1'b0;
         rresp_q          <= RESP_OKAY;
         rdata_q          <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               wait_q <= '0;
               if (grant_wr) begin
                  last_was_write_q <= 1'b1;
                  is_write_q       <= 1'b1;
                  if (aw_misaligned) begin
                     state_q  <= RESP_W;
                     bvalid_q <= 1'b1;
                     bresp_q  <= RESP_SLVERR;
                  end else begin
                     state_q      <= ACCESS;
                     rf_address_q <= i_awaddr;
                     rf_wr_data_q <= i_wdata;
                     rf_wr_strb_q <= i_wstrb;
                     rf_write_q   <= 1'b1;
                     rf_enable_q  <= 1'b1;
                  end
               end else if (grant_rd) begin
                  last_was_write_q <= 1'b0;
                  is_write_q       <= 1'b0;
                  if (ar_misaligned) begin
                     state_q  <= RESP_R;
                     rvalid_q <= 1'b1;
                     rresp_q  <= RESP_SLVERR;
                     rdata_q  <= '0;
                  end else begin
                     state_q      <= ACCESS;
                     rf_address_q <= i_araddr;
                     rf_wr_data_q <= '0;
                     rf_wr_strb_q <= '0;
                     rf_write_q   <= 1'b0;
                     rf_enable_q  <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               // Ready on the last allowed cycle takes priority over the timeout.
               if (i_rf_ready || timeout_hit) begin
                  rf_enable_q  <= 1'b0;
                  rf_write_q   <= 1'b0;
                  rf_address_q <= '0;
                  rf_wr_data_q <= '0;
                  rf_wr_strb_q <= '0;
                  if (is_write_q) begin
                     state_q  <= RESP_W;
                     bvalid_q <= 1'b1;
                     bresp_q  <= (i_rf_ready && !i_rf_error) ? RESP_OKAY : RESP_SLVERR;
                  end else begin
                     state_q  <= RESP_R;
                     rvalid_q <= 1'b1;
                     rresp_q  <= (i_rf_ready && !i_rf_error) ? RESP_OKAY : RESP_SLVERR;
                     rdata_q  <= i_rf_ready ? i_rf_rd_data : '0;
                  end
               end else begin
                  wait_q <= wait_q + 8'd1;
               end
            end
            RESP_W: begin
               if (i_bready) begin
                  state_q  <= IDLE;
                  bvalid_q <= 1'b0;
                  bresp_q  <= RESP_OKAY;
               end
            end
            RESP_R: begin
               if (i_rready) begin
                  state_q  <= IDLE;
                  rvalid_q <= 1'b0;
                  rresp_q  <= RESP_OKAY;
                  rdata_q  <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_bvalid     = bvalid_q;
   assign o_bresp      = bresp_q;
   assign o_rvalid     = rvalid_q;
   assign o_rresp      = rresp_q;
   assign o_rdata      = rdata_q;
   assign o_rf_address = rf_address_q;
   assign o_rf_wr_data = rf_wr_data_q;
   assign o_rf_wr_strb = rf_wr_strb_q;
   assign o_rf_write   = rf_write_q;
   assign o_rf_enable  = rf_enable_q;

endmodule

// File: doc/pt_axi4lite_rf_bridge.md
# pt_axi4lite_rf_bridge

Parametrised AXI4-Lite slave to register-file bridge, successor to the single-cycle bridge. Sits between an AXI4-Lite interconnect port and a Packtype-generated register block. Compared with the single-cycle bridge it adds:
- variable-latency downstream access with a ready handshake and a timeout;
- byte-strobe pass-through;
- misalignment rejection;
- fair read/write arbitration.

It serves exactly one transaction at a time.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 64, data width; must be 32 or 64
- TIMEOUT, 16, maximum downstream wait in cycles, 1..255; 0 disables the timeout
- STRB_W (localparam), DATA_W/8
- ALIGN_W (localparam), $clog2(STRB_W)

Ports:
- i_clk  in  1  clock; one clock domain
- i_rst  in  1  reset, synchronous, active-high
- i_awaddr in ADDR_W; i_awvalid in 1; o_awready out 1
- i_wdata in DATA_W; i_wstrb in STRB_W; i_wvalid in 1; o_wready out 1
- o_bresp out 2; o_bvalid out 1; i_bready in 1
- i_araddr in ADDR_W; i_arvalid in 1; o_arready out 1
- o_rdata out DATA_W; o_rresp out 2; o_rvalid out 1; i_rready in 1
- o_rf_address out ADDR_W; o_rf_wr_data out DATA_W; o_rf_wr_strb out STRB_W
- o_rf_write out 1; o_rf_enable out 1
- i_rf_rd_data in DATA_W; i_rf_ready in 1; i_rf_error in 1

## Operation
- FSM states: IDLE, ACCESS, RESP_W, RESP_R. Reset state is IDLE.
- Reset values: every output is 0. An i_rst assertion in any state returns the FSM to IDLE on the next edge and abandons the transaction; no response is issued for it.
- IDLE, write candidate: i_awvalid and i_wvalid are both high. The AW and W channels are never accepted separately.
- IDLE, read candidate: i_arvalid is high.
- IDLE, arbitration: if both candidates are present, the type not served last wins. A last_was_write flag tracks this; it resets to 0, so writes win first.
- IDLE, accept: ready is driven combinationally from the valids and the grant. Write: o_awready and o_wready both pulse. Read: o_arready pulses. Address, data and strobe are captured in the same cycle.
- Misaligned address (addr[ALIGN_W-1:0] != 0): no downstream access. Go directly to RESP_W or RESP_R with resp 2'b10 (SLVERR) and rdata 0.
- ACCESS, downstream drive: o_rf_enable=1, o_rf_write=1 for writes. Address, data and strobe are held stable. o_rf_wr_strb=0 for reads. o_rf_address is the full captured address.
- ACCESS, completion: completes on the cycle i_rf_ready=1. rdata is latched from i_rf_rd_data (reads only). resp = i_rf_error ? 2'b10 : 2'b00.
- ACCESS, timeout: an 8-bit wait counter is cleared on entry and increments each ACCESS cycle without i_rf_ready. If it reaches TIMEOUT-1 with no ready, leave ACCESS with SLVERR and rdata 0.
  - o_rf_enable is high for at most TIMEOUT cycles.
  - If i_rf_ready arrives on the final allowed cycle, ready wins.
- RESP_W / RESP_R: o_bvalid / o_rvalid is held with stable resp and data until the ready handshake, then the FSM returns to IDLE. When not valid, o_rdata is 0.
- The bridge generates only OKAY (2'b00) and SLVERR (2'b10) responses.

## Timing
- Zero-wait write: cycle 0 AW+W handshake; cycle 1 o_rf_enable with i_rf_ready; cycle 2 o_bvalid. Earliest next accept is cycle 3 if i_bready is high in cycle 2.
- Minimum throughput: 3 cycles per transaction.
- Misaligned access: response valid in cycle 1.
- N downstream wait cycles: response valid in cycle 2+N.
- Timeout: o_rf_enable high in cycles 1..TIMEOUT; SLVERR response valid in cycle TIMEOUT+1.
- No ready output is high outside IDLE. Valid outputs never drop without a handshake.

## Test plan
- Reset, then a write of 0xDEADBEEF_00000000 to 0x40 with wstrb=0xF0 and zero-wait RF. Required: o_rf_wr_strb=0xF0 in cycle 1; o_bvalid in cycle 2 with bresp=0.
- Read of 0x48 with i_rf_ready after 3 wait cycles and i_rf_rd_data=0x1234. Required: o_rvalid in cycle 5, o_rdata=0x1234, rresp=0. Hold i_rready low 4 cycles: rvalid and rdata stay stable.
- AW, W and AR all valid in the same cycle, repeated continuously. Required: write, read, write, read order; first grant is the write.
- Write to 0x44 with DATA_W=64. Required: o_rf_enable never asserts; bresp=2'b10 in cycle 1.
- TIMEOUT=4, i_rf_ready stuck low. Required: enable high exactly 4 cycles; rresp=2'b10, rdata=0. Also i_rf_error=1 with ready: SLVERR.
- i_rst asserted mid-ACCESS. Required: all outputs 0 on the next cycle. A subsequent read then completes normally.
